cernbe_axi4lite_master: RTL
===========================

Name: cernbe_axi4lite_master

Overview:
- Bridge that lets the CERN-BE bus drive an AXI4-Lite slave.
- On the CERN-BE side it is the target: it accepts VMERdMem/VMEWrMem strobes and returns VMERdDone/VMEWrDone.
- On the AXI4-Lite side it is the master: it issues single 32-bit transactions.
- It is the counterpart of our AXI4-Lite-slave-to-CERN-BE bridge, and is used to reach AXI peripherals from CERN-BE-mastered maps.

Parameters:
- ADDR_WIDTH, 16, width of VMEAddr_i, awaddr and araddr (byte address, passed through unchanged).

Ports:
- aclk  in  1  clock
- areset_n  in  1  asynchronous active-low reset
- VMEAddr_i  in  ADDR_WIDTH  CERN-BE address, sampled at request acceptance
- VMEWrData_i  in  32  write data, sampled at write acceptance
- VMERdMem_i  in  1  read strobe, held high until VMERdDone_o
- VMEWrMem_i  in  1  write strobe, held high until VMEWrDone_o
- VMERdData_o  out  32  read data, valid with VMERdDone_o and held afterwards
- VMERdDone_o  out  1  one-cycle read completion pulse
- VMEWrDone_o  out  1  one-cycle write completion pulse
- VMEErr_o  out  1  one-cycle pulse, coincident with a Done, when the AXI response is not OKAY
- awvalid out 1; awready in 1; awaddr out ADDR_WIDTH; awprot out 3
- wvalid out 1; wready in 1; wdata out 32; wstrb out 4
- bvalid in 1; bready out 1; bresp in 2
- arvalid out 1; arready in 1; araddr out ADDR_WIDTH; arprot out 3
- rvalid in 1; rready out 1; rdata in 32; rresp in 2

Behaviour:
- **Reset:**
  - All outputs are 0; FSM is in IDLE; strobe edge registers and the pending flag are cleared.
  - Asserting reset mid-transaction abandons it silently; no Done is issued.
- **Constant AXI fields:** awprot = arprot = 3'b000; wstrb = 4'hF.
- **Request detection:**
  - A request is the rising edge of a strobe: strobe = 1 and its registered previous value = 0.
  - A strobe still high in the cycle after Done therefore never re-triggers.
  - A new request needs the strobe to drop for at least one cycle.
- **Pending flag:**
  - A write edge seen while a transaction is busy sets wr_pend; a read edge sets rd_pend.
  - Addresses are latched when the transaction starts, so the master must hold VMEAddr_i, and VMEWrData_i for writes, until its Done.
- **Arbitration:** in IDLE, write (edge or pending) has priority over read. On simultaneous edges, the write runs first and the read is serviced immediately after.
- **FSM states:** IDLE, WR, WR_RESP, RD, RD_RESP.
  - IDLE, write selected: latch addr/data, assert awvalid and wvalid, go to WR (AXI valids are visible the cycle after edge detection).
  - WR:
    - awvalid drops in the cycle after awready is seen; wvalid drops in the cycle after wready is seen. The two are independent and may be accepted in any order or together.
    - When both have been accepted, go to WR_RESP.
  - WR_RESP:
    - bready = 1.
    - On bvalid: VMEWrDone_o pulses next cycle; VMEErr_o = (bresp != 0); go to IDLE.
  - IDLE, read selected: latch addr, assert arvalid, go to RD.
  - RD: on arready, drop arvalid and go to RD_RESP.
  - RD_RESP:
    - rready = 1.
    - On rvalid: register rdata into VMERdData_o, pulse VMERdDone_o next cycle, VMEErr_o = (rresp != 0), go to IDLE.
- **Latency:** with a zero-wait slave (ready/valid responding the cycle after valid), a write completes in 4 cycles from strobe rise to Done, and so does a read.
- **Valid stability:** valid signals are never dropped before their handshake completes, and address/data stay stable while valid is high.
- **No timeout:** the bridge waits indefinitely for the slave.
- **Outstanding transactions:** at most one AXI transaction is outstanding; reads and writes never overlap.

Decomposition:
- Shared package cernbe_axi_pkg holds:
  - the FSM state enum;
  - AXI_RESP_OKAY = 2'b00;
  - AXI_PROT_DEFAULT = 3'b000.
- No sub-module.
- Strobe edge detection is inline (two flops).

Test Plan:
- **Write, zero-wait:** VMEAddr=0x0010, WrData=0xDEADBEEF, strobe rises -> awaddr=0x0010, wdata=0xDEADBEEF, wstrb=F; with bresp=0, VMEWrDone_o pulses once 4 cycles after the rise, VMEErr_o=0.
- **Read with waits:** VMEAddr=0x0024; arready delayed 3 cycles, rvalid another 2 cycles with rdata=0x12345678 -> VMERdData_o=0x12345678 at the Done pulse and held afterwards; arvalid held stable throughout.
- **Skewed write handshake:** wready arrives 2 cycles before awready -> wvalid drops first, awvalid stays high until awready, exactly one Done.
- **Simultaneous requests:** both strobes rise in the same cycle -> AXI write completes first, then the read is issued; each Done pulses exactly once; strobes held high after Done cause no second transaction.
- **Error responses:** bresp=2'b10 -> VMEWrDone_o and VMEErr_o pulse together; rresp=2'b11 -> VMERdDone_o and VMEErr_o pulse together.
- **Reset mid-transaction:** areset_n low while in WR_RESP -> all AXI valids/readies are 0 immediately with no Done; after release, a fresh strobe edge works normally.

Source files
------------

// File: rtl/cernbe_axi_pkg.sv
// Shared types and constants for the CERN-BE to AXI4-Lite master bridge.
package cernbe_axi_pkg;

  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

  localparam logic [1:0] AXI_RESP_OKAY    = 2'b00;
  localparam logic [2:0] AXI_PROT_DEFAULT = 3'b000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR,
    ST_WR_RESP,
    ST_RD,
    ST_RD_RESP
  } state_t;

endpackage

// File: rtl/cernbe_axi4lite_master.sv
// CERN-BE target to AXI4-Lite master bridge: one single-beat 32-bit
// AXI transaction per CERN-BE strobe edge, writes ahead of reads.
module cernbe_axi4lite_master
  import cernbe_axi_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 16
) (
  input  logic                    aclk,
  input  logic                    areset_n,
  input  logic [ADDR_WIDTH-1:0]   VMEAddr_i,
  input  logic [DATA_WIDTH-1:0]   VMEWrData_i,
  input  logic                    VMERdMem_i,
  input  logic                    VMEWrMem_i,
  output logic [DATA_WIDTH-1:0]   VMERdData_o,
  output logic                    VMERdDone_o,
  output logic                    VMEWrDone_o,
  output logic                    VMEErr_o,
  output logic                    awvalid,
  input  logic                    awready,
  output logic [ADDR_WIDTH-1:0]   awaddr,
  output logic [2:0]              awprot,
  output logic                    wvalid,
  input  logic                    wready,
  output logic [DATA_WIDTH-1:0]   wdata,
  output logic [STRB_WIDTH-1:0]   wstrb,
  input  logic                    bvalid,
  output logic                    bready,
  input  logic [1:0]              bresp,
  output logic                    arvalid,
  input  logic                    arready,
  output logic [ADDR_WIDTH-1:0]   araddr,
  output logic [2:0]              arprot,
  input  logic                    rvalid,
  output logic                    rready,
  input  logic [DATA_WIDTH-1:0]   rdata,
  input  logic [1:0]              rresp
);

  state_t                  state, state_n;
  logic                    wr_prev, rd_prev;
  logic                    wr_pend, wr_pend_n, rd_pend, rd_pend_n;
  logic                    wr_edge, rd_edge;
  logic                    awvalid_n, wvalid_n, arvalid_n, bready_n, rready_n;
  logic [ADDR_WIDTH-1:0]   awaddr_n, araddr_n;
  logic [DATA_WIDTH-1:0]   wdata_n, rd_data_n;
  logic                    wr_done_n, rd_done_n, err_n;

  assign awprot = AXI_PROT_DEFAULT;
  assign arprot = AXI_PROT_DEFAULT;
  assign wstrb  = {STRB_WIDTH{1'b1}};

  assign wr_edge = VMEWrMem_i & ~wr_prev;
  assign rd_edge = VMERdMem_i & ~rd_prev;

  // State, strobe history and all registered outputs
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      state       <= ST_IDLE;
      wr_prev     <= 1'b0;
      rd_prev     <= 1'b0;
      wr_pend     <= 1'b0;
      rd_pend     <= 1'b0;
      awvalid     <= 1'b0;
      wvalid      <= 1'b0;
      arvalid     <= 1'b0;
      bready      <= 1'b0;
      rready      <= 1'b0;
      awaddr      <= '0;
      araddr      <= '0;
      wdata       <= '0;
      VMERdData_o <= '0;
      VMEWrDone_o <= 1'b0;
      VMERdDone_o <= 1'b0;
      VMEErr_o    <= 1'b0;
    end else begin
      state       <= state_n;
      wr_prev     <= VMEWrMem_i;
      rd_prev     <= VMERdMem_i;
      wr_pend     <= wr_pend_n;
      rd_pend     <= rd_pend_n;
      awvalid     <= awvalid_n;
      wvalid      <= wvalid_n;
      arvalid     <= arvalid_n;
      bready      <= bready_n;
      rready      <= rready_n;
      awaddr      <= awaddr_n;
      araddr      <= araddr_n;
      wdata       <= wdata_n;
      VMERdData_o <= rd_data_n;
      VMEWrDone_o <= wr_done_n;
      VMERdDone_o <= rd_done_n;
      VMEErr_o    <= err_n;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_n   = state;
    wr_pend_n = wr_pend | wr_edge;
    rd_pend_n = rd_pend | rd_edge;
    awvalid_n = awvalid;
    wvalid_n  = wvalid;
    arvalid_n = arvalid;
    bready_n  = bready;
    rready_n  = rready;
    awaddr_n  = awaddr;
    araddr_n  = araddr;
    wdata_n   = wdata;
    rd_data_n = VMERdData_o;
    wr_done_n = 1'b0;
    rd_done_n = 1'b0;
    err_n     = 1'b0;

    unique case (state)
      ST_IDLE: begin
        if (wr_edge || wr_pend) begin
          state_n   = ST_WR;
          wr_pend_n = 1'b0;
          awvalid_n = 1'b1;
          wvalid_n  = 1'b1;
          awaddr_n  = VMEAddr_i;
          wdata_n   = VMEWrData_i;
        end else if (rd_edge || rd_pend) begin
          state_n   = ST_RD;
          rd_pend_n = 1'b0;
          arvalid_n = 1'b1;
          araddr_n  = VMEAddr_i;
        end
      end
      ST_WR: begin
        // Address and data channels complete independently
        if (awready) awvalid_n = 1'b0;
        if (wready)  wvalid_n  = 1'b0;
        if ((!awvalid || awready) && (!wvalid || wready)) begin
          state_n  = ST_WR_RESP;
          bready_n = 1'b1;
        end
      end
      ST_WR_RESP: begin
        if (bvalid) begin
          state_n   = ST_IDLE;
          bready_n  = 1'b0;
          wr_done_n = 1'b1;
          err_n     = (bresp != AXI_RESP_OKAY);
        end
      end
      ST_RD: begin
        if (arready) begin
          state_n   = ST_RD_RESP;
          arvalid_n = 1'b0;
          rready_n  = 1'b1;
        end
      end
      ST_RD_RESP: begin
        if (rvalid) begin
          state_n   = ST_IDLE;
          rready_n  = 1'b0;
          rd_data_n = rdata;
          rd_done_n = 1'b1;
          err_n     = (rresp != AXI_RESP_OKAY);
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

endmodule
